mem_ift_slave: RTL and testbench

- Memory-side responder for the Mem_ift protocol; it is the slave end of the cache's master port.
- Read channel: it accepts 128-bit beat requests (raddr/ren) and returns rdata with an rvalid pulse after a programmable latency.
- Write channel: it accepts masked 128-bit beat writes (waddr/wdata/wmask/wen) and acknowledges each with wvalid.
- It is the backing main-memory model/controller placed behind the CMU for simulation and FPGA builds.

---
 rtl/mem_ift_slave.sv | 134 +++++++++++++
 tb/tb_mem_ift_slave.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ift_slave.sv
// Mem_ift memory-side responder: single-port beat array with a fixed,
// programmable response latency for reads and byte-masked writes.
module mem_ift_slave #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_DEPTH  = 4096,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ren_mem,
    input  logic [ADDR_WIDTH-1:0]     raddr_mem,
    output logic [DATA_WIDTH*2-1:0]   rdata_mem,
    output logic                      rvalid_mem,
    input  logic                      wen_mem,
    input  logic [ADDR_WIDTH-1:0]     waddr_mem,
    input  logic [DATA_WIDTH*2-1:0]   wdata_mem,
    input  logic [DATA_WIDTH*2/8-1:0] wmask_mem,
    output logic                      wvalid_mem
);

    localparam int unsigned BEAT_W   = DATA_WIDTH * 2;
    localparam int unsigned MASK_W   = BEAT_W / 8;
    localparam int unsigned B        = $clog2(MASK_W);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRBusy,
        StWBusy,
        StRDone,
        StWDone
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BEAT_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                rd_fire, wr_fire;

    logic [BEAT_W-1:0]   mem [MEM_DEPTH];

    // Only the beat-index field of each address is meaningful.
    logic unused_addr;
    assign unused_addr = ^{raddr_mem[ADDR_WIDTH-1:IDX_W+B], raddr_mem[B-1:0],
                           waddr_mem[ADDR_WIDTH-1:IDX_W+B], waddr_mem[B-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Writes win so a writeback drains before the dependent refill.
                if (wen_mem) begin
                    state_d = StWBusy;
                    cnt_d   = CNT_INIT;
                    idx_d   = waddr_mem[IDX_W+B-1:B];
                    wdata_d = wdata_mem;
                    wmask_d = wmask_mem;
                end else if (ren_mem) begin
                    state_d = StRBusy;
                    cnt_d   = CNT_INIT;
                    idx_d   = raddr_mem[IDX_W+B-1:B];
                end
            end
            StRBusy: begin
                if (!ren_mem) begin
                    state_d = StIdle;
                end else if (cnt_q == 8'd0) begin
                    state_d = StRDone;
                    rd_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StWBusy: begin
                if (!wen_mem) begin
                    state_d = StIdle;
                end else if (cnt_q == 8'd0) begin
                    state_d = StWDone;
                    wr_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StRDone: begin
                if (!ren_mem) state_d = StIdle;
            end
            StWDone: begin
                if (!wen_mem) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rvalid_mem <= 1'b0;
            wvalid_mem <= 1'b0;
            rdata_mem  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rvalid_mem <= rd_fire;
            wvalid_mem <= wr_fire;
            if (rd_fire) rdata_mem <= mem[idx_q];
        end
    end

    // Array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_ift_slave.sv
// Self-checking bench for mem_ift_slave: transaction-level model of the beat
// array plus a per-cycle checker of the response pulses and read data.
module tb_mem_ift_slave;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BW    = DW * 2;
    localparam int MW    = BW / 8;
    localparam int L     = 4;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ren_mem = 1'b0;
    logic [AW-1:0] raddr_mem = '0;
    logic [BW-1:0] rdata_mem;
    logic          rvalid_mem;
    logic          wen_mem = 1'b0;
    logic [AW-1:0] waddr_mem = '0;
    logic [BW-1:0] wdata_mem = '0;
    logic [MW-1:0] wmask_mem = '0;
    logic          wvalid_mem;

    mem_ift_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH (DEPTH),
        .LATENCY   (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ren_mem   (ren_mem),
        .raddr_mem (raddr_mem),
        .rdata_mem (rdata_mem),
        .rvalid_mem(rvalid_mem),
        .wen_mem   (wen_mem),
        .waddr_mem (waddr_mem),
        .wdata_mem (wdata_mem),
        .wmask_mem (wmask_mem),
        .wvalid_mem(wvalid_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: array contents, and the cycle index (cyc value) during
    // which each pulse must be visible.
    logic [BW-1:0] model_mem [int];
    int            exp_r_cyc = -1;
    int            exp_w_cyc = -1;
    logic [BW-1:0] exp_rdata = '0;
    logic [BW-1:0] hold_rdata = '0;

    localparam logic [BW-1:0] PAT_A  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [BW-1:0] ALL_55 = {16{8'h55}};
    localparam logic [BW-1:0] ALL_AA = {16{8'hAA}};
    localparam logic [BW-1:0] MERGED = 128'h5555555555555555AAAAAAAAAAAAAAAA;
    localparam logic [BW-1:0] PAT_W  = 128'hDEADBEEF00112233445566778899AABB;
    localparam logic [BW-1:0] PAT_Z  = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;
    localparam logic [BW-1:0] PAT_1  = 128'h11111111222222223333333344444444;
    localparam logic [BW-1:0] PAT_6  = 128'h66666666666666667777777777777777;

    task automatic check(input string name, input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    endtask

    function automatic int beat_idx(input logic [AW-1:0] a);
        return int'((a / 64'd16) % 64'(DEPTH));
    endfunction

    function automatic logic [BW-1:0] merge(input logic [BW-1:0] old,
                                            input logic [BW-1:0] data,
                                            input logic [MW-1:0] mask);
        logic [BW-1:0] r = old;
        for (int i = 0; i < MW; i++) if (mask[i]) r[i*8 +: 8] = data[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [BW-1:0] model_rd(input logic [AW-1:0] a);
        return model_mem.exists(beat_idx(a)) ? model_mem[beat_idx(a)] : '0;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("rvalid", {127'd0, rvalid_mem}, {127'd0, cyc == exp_r_cyc});
            check("wvalid", {127'd0, wvalid_mem}, {127'd0, cyc == exp_w_cyc});
            if (cyc == exp_r_cyc) begin
                check("rdata", rdata_mem, exp_rdata);
                hold_rdata = exp_rdata;
            end else begin
                check("rdata_hold", rdata_mem, hold_rdata);
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d,
                            input logic [MW-1:0] m);
        @(negedge clk);
        wen_mem = 1'b1; waddr_mem = a; wdata_mem = d; wmask_mem = m;
        exp_w_cyc = cyc + 1 + L;
        while (cyc < exp_w_cyc) @(negedge clk);
        model_mem[beat_idx(a)] = merge(model_rd(a), d, m);
        wen_mem = 1'b0; wdata_mem = '0; wmask_mem = '0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold,
                           output logic [BW-1:0] got);
        @(negedge clk);
        ren_mem = 1'b1; raddr_mem = a;
        exp_rdata = model_rd(a);
        exp_r_cyc = cyc + 1 + L;
        while (cyc < exp_r_cyc) @(negedge clk);
        got = rdata_mem;
        repeat (hold) @(negedge clk);
        ren_mem = 1'b0;
        @(negedge clk);
    endtask

    logic [BW-1:0] got;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rvalid", {127'd0, rvalid_mem}, '0);
        check("reset_wvalid", {127'd0, wvalid_mem}, '0);
        check("reset_rdata", rdata_mem, '0);
        rst = 1'b0;
        @(negedge clk);

        // Preload and basic read, held 3 cycles beyond the pulse.
        do_write(64'h20, PAT_A, 16'hFFFF);
        do_read(64'h20, 3, got);
        check("read_beat2", got, PAT_A);

        // Masked write over 0x55 background.
        do_write(64'h30, ALL_55, 16'hFFFF);
        do_write(64'h30, ALL_AA, 16'h00FF);
        do_read(64'h30, 0, got);
        check("masked_merge", got, MERGED);

        // Simultaneous write and read to the same beat: write first.
        do_write(64'h40, PAT_Z, 16'hFFFF);
        @(negedge clk);
        wen_mem = 1'b1; ren_mem = 1'b1;
        waddr_mem = 64'h40; raddr_mem = 64'h40;
        wdata_mem = PAT_W; wmask_mem = 16'hFFFF;
        exp_w_cyc = cyc + 1 + L;
        exp_r_cyc = cyc + 3 + 2 * L;
        exp_rdata = PAT_W;
        while (cyc < exp_w_cyc) @(negedge clk);
        model_mem[beat_idx(64'h40)] = PAT_W;
        wen_mem = 1'b0;
        while (cyc < exp_r_cyc) @(negedge clk);
        got = rdata_mem;
        ren_mem = 1'b0;
        @(negedge clk);
        check("wr_then_rd", got, PAT_W);

        // Address wrap modulo MEM_DEPTH beats.
        do_write(64'h0, PAT_1, 16'hFFFF);
        do_write(64'h10010, PAT_6, 16'hFFFF);
        do_read(64'h00010, 0, got);
        check("wrap_alias", got, PAT_6);
        do_read(64'h1000F, 0, got);
        check("wrap_beat0", got, PAT_1);

        // Read aborted two cycles into the busy phase.
        @(negedge clk);
        ren_mem = 1'b1; raddr_mem = 64'h30;
        exp_r_cyc = cyc + 1 + L;
        repeat (3) @(negedge clk);
        ren_mem = 1'b0;
        exp_r_cyc = -1;
        repeat (2) @(negedge clk);
        do_read(64'h20, 0, got);
        check("after_abort", got, PAT_A);

        // Asynchronous reset in the middle of a write.
        do_write(64'h60, PAT_6, 16'hFFFF);
        @(negedge clk);
        wen_mem = 1'b1; waddr_mem = 64'h60; wdata_mem = PAT_W; wmask_mem = 16'hFFFF;
        exp_w_cyc = cyc + 1 + L;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_w_cyc = -1;
        hold_rdata = '0;
        #1;
        check("arst_rvalid", {127'd0, rvalid_mem}, '0);
        check("arst_wvalid", {127'd0, wvalid_mem}, '0);
        check("arst_rdata", rdata_mem, '0);
        @(negedge clk);
        wen_mem = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(64'h60, 0, got);
        check("arst_no_write", got, PAT_6);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
